// File: rtl/xorexec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xorexec_pkg
// Purpose : Shared types and helpers for the xorexec ingress arbiter.
//           - xorexec_state_e : packet-walk states (IDLE / HDR / PAY)
//           - c_DEF_DW, c_DEF_LEN_W : default byte and length-field widths
//           - hdr_len()       : extracts the payload-length field of a header
// Revision: 1.0 - initial release
// ============================================================================
package xorexec_pkg;

  localparam int c_DEF_DW    = 8;
  localparam int c_DEF_LEN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } xorexec_state_e;

  // Keeps only the low len_w bits of a header; upper header bits carry
  // information for downstream logic and are ignored here.
  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int len_w);
    hdr_len = hdr & ((32'd1 << len_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xorexec_ingress_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Purely combinational round-robin selector. Searches req upward
//           starting at rr_ptr (with wrap) and returns the first set bit.
// Ports   : req    in  NREQ   request vector
//           rr_ptr in  PTR_W  index where the search starts (0..NREQ-1)
//           pick   out NREQ   one-hot winner, 0 when no request
//           any    out 1      at least one request is set
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any
);

  assign any = |req;

  always_comb begin : p_pick
    int               w_idx;
    logic             w_found;
    logic [PTR_W-1:0] w_sel;
    pick    = '0;
    w_idx   = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(rr_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      w_sel = PTR_W'(w_idx);
      if (!w_found && req[w_sel]) begin
        pick[w_sel] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xorexec_ingress_arb.sv
`default_nettype none
// ============================================================================
// Module  : xorexec_ingress_arb
// Purpose : Packet-atomic round-robin arbiter sharing the xorexec input FIFO
//           between NREQ requesters. A packet is one header byte whose low
//           LEN_W bits give the payload count, followed by that many bytes.
//           A grant is held until the whole packet has been pushed.
// Ports   : clk            in  1        clock, rising edge
//           rst_n          in  1        asynchronous active-low reset
//           pwr_on         in  1        0 blocks new grants, stalls transfers
//           req_valid      in  NREQ     requester i presents a byte
//           req_data       in  NREQ*DW  requester i byte at [i*DW +: DW]
//           req_ready      out NREQ     byte of requester i accepted
//           ififo_not_full in  1        FIFO can accept a byte
//           ififo_push     out 1        push strobe to the FIFO
//           idata          out DW       byte to the FIFO
//           gnt            out NREQ     one-hot owner, 0 when idle
//           busy           out 1        packet in flight
//           pkt_cnt        out NREQ*16  per-requester completed packets
//                                       (only with XORARB_STATS_EN defined)
// Options : `define XORARB_STATS_EN adds the pkt_cnt counters/port.
// Revision: 1.0 - initial release
// ============================================================================
module xorexec_ingress_arb
  import xorexec_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = c_DEF_DW,
  parameter int LEN_W = c_DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_on,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               ififo_not_full,
  output logic               ififo_push,
  output logic [DW-1:0]      idata,
  output logic [NREQ-1:0]    gnt,
  output logic               busy
`ifdef XORARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] pkt_cnt
`endif
);

  localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  xorexec_state_e     r_state, w_state_nxt;
  logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
  logic [c_PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;

  logic [NREQ-1:0]    w_pick;
  logic               w_any;
  logic [c_PTR_W-1:0] w_gidx;
  logic [c_PTR_W-1:0] w_gidx_inc;
  logic [DW-1:0]      w_gdata;
  logic               w_gvalid;
  logic               w_active;
  logic               w_open;
  logic               w_xfer;
  logic               w_done;
  logic [LEN_W-1:0]   w_hdr_len;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_PTR_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .pick   (w_pick),
    .any    (w_any)
  );

  // Decode the one-hot grant into an index and steer the owner's byte.
  // With no grant the mux yields 0, which is what idata shows in reset.
  always_comb begin
    w_gidx   = '0;
    w_gdata  = '0;
    w_gvalid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) begin
        w_gidx   = c_PTR_W'(i);
        w_gdata  = req_data[i*DW +: DW];
        w_gvalid = req_valid[i];
      end
    end
  end

  assign w_gidx_inc = (w_gidx == c_PTR_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_hdr_len  = LEN_W'(hdr_len(32'(w_gdata), LEN_W));

  assign w_active   = (r_state != ST_IDLE);
  assign w_open     = w_active & pwr_on & ififo_not_full;
  assign w_xfer     = w_open & w_gvalid;

  assign req_ready  = w_open ? r_gnt : '0;
  assign ififo_push = w_xfer;
  assign idata      = w_gdata;
  assign gnt        = r_gnt;
  assign busy       = w_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Without a transfer every register holds, which covers FIFO-full,
  // requester-not-valid and power-off stalls alike.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pwr_on && w_any) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          w_cnt_nxt = w_hdr_len;
          if (w_hdr_len == '0) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            w_done = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_done) begin
      w_state_nxt  = ST_IDLE;
      w_gnt_nxt    = '0;
      w_rr_ptr_nxt = w_gidx_inc;
    end
  end

`ifdef XORARB_STATS_EN
  logic [15:0] r_pkt_cnt [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pkt_cnt[i] <= '0;
        end else if (w_done && r_gnt[i]) begin
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
        end
      end
      assign pkt_cnt[i*16 +: 16] = r_pkt_cnt[i];
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_xorexec_ingress_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_xorexec_ingress_arb
// Purpose : Self-checking bench for xorexec_ingress_arb. Requesters are
//           byte queues holding whole packets; a packet-level reference model
//           (owner index, bytes left, round-robin start) predicts every
//           output each cycle. Directed scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xorexec_ingress_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int LEN_W = 3;

  logic               clk;
  logic               rst_n;
  logic               pwr_on;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               ififo_not_full;
  logic               ififo_push;
  logic [DW-1:0]      idata;
  logic [NREQ-1:0]    gnt;
  logic               busy;
`ifdef XORARB_STATS_EN
  logic [NREQ*16-1:0] pkt_cnt;
`endif

  xorexec_ingress_arb #(
    .NREQ  (NREQ),
    .DW    (DW),
    .LEN_W (LEN_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwr_on         (pwr_on),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .ififo_not_full (ififo_not_full),
    .ififo_push     (ififo_push),
    .idata          (idata),
    .gnt            (gnt),
    .busy           (busy)
`ifdef XORARB_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: who owns the FIFO, whether the header is still due,
  // how many payload bytes remain, and where the next search starts.
  int m_owner = -1;
  bit m_hdr   = 1'b0;
  int m_left  = 0;
  int m_rr    = 0;

  logic [DW-1:0]   txq [NREQ][$];
  int              push_cyc [$];
  logic [DW-1:0]   push_dat [$];
  logic [NREQ-1:0] gnt_log  [$];
  bit              busy_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic enq_pkt(input int r, input logic [DW-1:0] hdr, input logic [DW-1:0] base);
    int n;
    n = int'(hdr) % (1 << LEN_W);
    txq[r].push_back(hdr);
    for (int k = 0; k < n; k++) txq[r].push_back(base + DW'(k));
  endtask

  // Valid only when a byte is queued; data always shows the queue head so a
  // waiting requester holds its byte stable.
  task automatic drive(input int pv);
    for (int i = 0; i < NREQ; i++) begin
      if (txq[i].size() > 0) begin
        req_data[i*DW +: DW] = txq[i][0];
        req_valid[i] = ($urandom_range(99) < pv);
      end else begin
        req_data[i*DW +: DW] = DW'($urandom);
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_rdy;
    bit              e_push;
    logic [DW-1:0]   b;
    bit              found;
    int              idx;
    @(negedge clk);
    e_gnt  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e_rdy  = (m_owner >= 0 && pwr_on && ififo_not_full) ? e_gnt : '0;
    e_push = (m_owner >= 0) && (e_rdy != '0) && req_valid[m_owner];
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("ififo_push", 32'(ififo_push), 32'(e_push));
    if (e_push && txq[m_owner].size() > 0) chk("idata", 32'(idata), 32'(txq[m_owner][0]));
    if (ififo_push === 1'b1) begin
      push_cyc.push_back(cyc);
      push_dat.push_back(idata);
    end
    gnt_log.push_back(gnt);
    busy_log.push_back(busy);
    @(posedge clk);
    if (e_push) begin
      b = txq[m_owner].pop_front();
      if (m_hdr) begin
        m_hdr  = 1'b0;
        m_left = int'(b) % (1 << LEN_W);
      end else begin
        m_left = m_left - 1;
      end
      if (m_left == 0) begin
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end else if (m_owner < 0 && pwr_on && req_valid != '0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_hdr   = 1'b1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive(100);
      cycle();
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) txq[i].delete();
    m_owner = -1;
    m_hdr   = 1'b0;
    m_left  = 0;
    m_rr    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, t1, p0, pending;
    logic [DW-1:0] exp1 [4];
    logic [NREQ-1:0] order [5];
    logic [DW-1:0] exp4 [5];
    rst_n = 1'b0;
    pwr_on = 1'b1;
    ififo_not_full = 1'b1;
    req_valid = '0;
    req_data = '0;
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_push", 32'(ififo_push), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_idata", 32'(idata), 32'd0);

    // Single packet 03 A1 A2 A3 from requester 0
    exp1[0] = 8'h03; exp1[1] = 8'hA1; exp1[2] = 8'hA2; exp1[3] = 8'hA3;
    enq_pkt(0, 8'h03, 8'hA1);
    t0 = cyc; p0 = push_cyc.size();
    run(6);
    chk("t1_npush", 32'(push_cyc.size() - p0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_pcyc", 32'(push_cyc[p0+k] - t0), 32'(1 + k));
      chk("t1_pdat", 32'(push_dat[p0+k]), 32'(exp1[k]));
    end
    chk("t1_busy_on", 32'(busy_log[t0+4]), 32'd1);
    chk("t1_busy_off", 32'(busy_log[t0+5]), 32'd0);

    // Zero-length packet from requester 2
    enq_pkt(2, 8'h00, 8'h00);
    t0 = cyc; p0 = push_cyc.size();
    run(4);
    chk("t2_npush", 32'(push_cyc.size() - p0), 32'd1);
    chk("t2_pcyc", 32'(push_cyc[p0] - t0), 32'd1);
    chk("t2_pdat", 32'(push_dat[p0]), 32'h00);
    chk("t2_gnt", 32'(gnt_log[t0+1]), 32'b0100);
    chk("t2_gnt_clr", 32'(gnt_log[t0+2]), 32'd0);

    // Contention: all four hold valid with 2-byte packets from rr_ptr=0
    do_reset();
    enq_pkt(0, 8'h01, 8'h10);
    enq_pkt(0, 8'h01, 8'h14);
    enq_pkt(1, 8'h01, 8'h11);
    enq_pkt(2, 8'h01, 8'h12);
    enq_pkt(3, 8'h01, 8'h13);
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    t0 = cyc; p0 = push_cyc.size();
    run(16);
    chk("t3_npush", 32'(push_cyc.size() - p0), 32'd10);
    for (int k = 0; k < 5; k++) begin
      chk("t3_gnt", 32'(gnt_log[t0+1+3*k]), 32'(order[k]));
      if (push_cyc.size() >= p0 + 2*k + 2) begin
        chk("t3_hcyc", 32'(push_cyc[p0+2*k] - t0), 32'(1 + 3*k));
        chk("t3_pcyc", 32'(push_cyc[p0+2*k+1] - t0), 32'(2 + 3*k));
      end
    end
    chk("t3_bubble", 32'(busy_log[t0+3]), 32'd0);

    // Backpressure mid-PAY for 5 cycles
    exp4[0] = 8'h04; exp4[1] = 8'hC0; exp4[2] = 8'hC1; exp4[3] = 8'hC2; exp4[4] = 8'hC3;
    enq_pkt(1, 8'h04, 8'hC0);
    t0 = cyc; p0 = push_cyc.size();
    run(3);
    ififo_not_full = 1'b0;
    run(5);
    ififo_not_full = 1'b1;
    run(5);
    chk("t4_npush", 32'(push_cyc.size() - p0), 32'd5);
    if (push_cyc.size() >= p0 + 5) begin
      chk("t4_resume", 32'(push_cyc[p0+2] - t0), 32'd8);
      chk("t4_last", 32'(push_cyc[p0+4] - t0), 32'd10);
      for (int k = 0; k < 5; k++) chk("t4_pdat", 32'(push_dat[p0+k]), 32'(exp4[k]));
    end
    chk("t4_gnt_held", 32'(gnt_log[t0+5]), 32'b0010);
    chk("t4_busy_off", 32'(busy_log[t0+11]), 32'd0);

    // Power: no grant while off in IDLE, stall mid-packet
    pwr_on = 1'b0;
    enq_pkt(3, 8'h01, 8'hD0);
    t0 = cyc; p0 = push_cyc.size();
    run(4);
    chk("t5_nogrant", 32'(gnt_log[t0+3]), 32'd0);
    chk("t5_nopush", 32'(push_cyc.size() - p0), 32'd0);
    pwr_on = 1'b1;
    t1 = cyc;
    run(2);
    pwr_on = 1'b0;
    run(3);
    pwr_on = 1'b1;
    run(3);
    chk("t5_npush", 32'(push_cyc.size() - p0), 32'd2);
    if (push_cyc.size() >= p0 + 2) begin
      chk("t5_hcyc", 32'(push_cyc[p0] - t1), 32'd1);
      chk("t5_pcyc", 32'(push_cyc[p0+1] - t1), 32'd5);
    end
    chk("t5_gnt_held", 32'(gnt_log[t1+3]), 32'b1000);
    chk("t5_busy_off", 32'(busy_log[t1+6]), 32'd0);

    // Move the round-robin start away from 0, then reset mid-PAY
    enq_pkt(1, 8'h00, 8'h00);
    run(3);
    enq_pkt(2, 8'h03, 8'hE0);
    run(3);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_gnt_pre", 32'(gnt), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_push", 32'(ififo_push), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    do_reset();
    enq_pkt(2, 8'h01, 8'hF2);
    enq_pkt(0, 8'h01, 8'hF0);
    t0 = cyc;
    run(8);
    chk("t6_gnt_after", 32'(gnt_log[t0+1]), 32'b0001);

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(99) < 30) begin
        int r;
        r = int'($urandom_range(NREQ - 1));
        if (txq[r].size() < 24) enq_pkt(r, DW'($urandom), DW'($urandom));
      end
      pwr_on         = ($urandom_range(99) < 90);
      ififo_not_full = ($urandom_range(99) < 80);
      drive(70);
      cycle();
    end

    // Drain with a bounded budget
    pwr_on = 1'b1;
    ififo_not_full = 1'b1;
    pending = 1;
    for (int it = 0; it < 2000 && pending != 0; it++) begin
      drive(100);
      cycle();
      pending = (m_owner >= 0) ? 1 : 0;
      for (int i = 0; i < NREQ; i++) if (txq[i].size() > 0) pending = 1;
    end
    chk("drain_done", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xorexec_ingress_arb.md
Name: xorexec_ingress_arb

Overview:
- Packet-atomic round-robin arbiter that shares the single xorexec input FIFO (ififo_push/idata/ififo_not_full) between NREQ requesters.
- A packet is one header byte followed by payload bytes. Header bits [LEN_W-1:0] give the payload count, 0..2^LEN_W-1.
- Once a requester is granted, the grant is held until its whole packet has been pushed, so packets never interleave in the FIFO.
- The block sits between the requester agents and top_xorexec's ingress port, and is gated by pwr_on.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data byte width
LEN_W, 3, width of the payload-length field in header bits [LEN_W-1:0]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pwr_on  in  1  power-domain on; 0 blocks new grants and stalls transfers
req_valid  in  NREQ  requester i presents a byte
req_data  in  NREQ*DW  requester i byte at [i*DW +: DW]
req_ready  out  NREQ  byte of requester i accepted this cycle when valid&ready
ififo_not_full  in  1  xorexec input FIFO can accept a byte
ififo_push  out  1  push strobe to the FIFO
idata  out  DW  byte to the FIFO
gnt  out  NREQ  one-hot current owner, 0 when idle
busy  out  1  packet in flight (state != IDLE)

Behaviour:
- States: IDLE, HDR, PAY. Registered: state, gnt, rr_ptr (index), cnt (LEN_W bits).
- Reset (async, rst_n=0): state=IDLE, gnt=0, rr_ptr=0, cnt=0, so req_ready=0, ififo_push=0, busy=0. The idata value during reset is don't-care; drive 0.
- IDLE:
  - If pwr_on=1 and any req_valid is set, pick the first valid requester searching from rr_ptr upward with wrap.
  - Register the one-hot choice into gnt and go to HDR.
  - No transfer happens in IDLE, so there is a 1-cycle bubble between packets.
- Transfer condition: xfer = (state!=IDLE) & pwr_on & ififo_not_full & req_valid[g], where g is the granted index.
- Combinational outputs:
  - req_ready[g] = (state!=IDLE) & pwr_on & ififo_not_full.
  - Other req_ready bits are 0.
  - ififo_push = xfer; idata = req_data[g].
  - Zero latency from requester to FIFO.
- HDR:
  - On xfer, cnt <= req_data[g][LEN_W-1:0].
  - If that field is 0, go to IDLE (packet complete); otherwise go to PAY.
- PAY:
  - On xfer, cnt <= cnt-1.
  - If cnt==1 at the xfer, go to IDLE (packet complete).
- Packet complete: gnt<=0 and rr_ptr <= (g+1) mod NREQ.
- Stalls keep state, gnt and cnt unchanged:
  - FIFO full: ififo_not_full=0.
  - Requester not valid: req_valid[g]=0.
  - Power off: pwr_on=0.
- pwr_on falling mid-packet: the grant is held and transfers stall; the packet resumes when pwr_on returns. Never abort.
- Non-granted requesters always see ready=0 and must hold their data.
- Reset mid-packet: immediate return to IDLE. The partial packet is already in the FIFO; flushing it is the system's responsibility.
- Header data bits above LEN_W-1 are passed through unchanged and ignored by this block.

Optional Feature:
XORARB_STATS_EN
- Defined:
  - Adds output pkt_cnt, NREQ*16 bits: a per-requester 16-bit count of completed packets.
  - A counter increments on packet complete and wraps at 0xFFFF->0.
  - Counters reset to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package xorexec_pkg:
  - State enum (IDLE/HDR/PAY).
  - Default DW/LEN_W constants.
  - Header length-field slice helper.
- Sub-module rr_pick:
  - Purely combinational round-robin selector.
  - Inputs: req vector, rr_ptr. Outputs: one-hot winner, any-valid.
  - Instantiated once in xorexec_ingress_arb.

Test Plan:
- Reset then single packet: req0 sends header 0x03 and bytes A1, A2, A3, FIFO never full -> 4 ififo_push pulses on consecutive cycles starting 1 cycle after req_valid, idata=03, A1, A2, A3; busy drops on the next cycle; rr_ptr=1.
- Zero-length packet: header 0x00 from req2 -> exactly 1 push, HDR->IDLE, gnt cleared next cycle.
- Contention: all 4 requesters hold valid with 2-byte packets (header 0x01), rr_ptr=0 -> grant order 0,1,2,3,0; no interleaving; 1 idle cycle between packets.
- Backpressure: ififo_not_full=0 for 5 cycles mid-PAY -> no push, req_ready=0, cnt held; the packet resumes with the correct remaining byte count.
- Power: pwr_on=0 in IDLE with req valid -> no grant. pwr_on=0 mid-packet -> stall with gnt held, completing after pwr_on=1.
- Async reset asserted mid-PAY (cnt=2) -> outputs go 0 immediately with no clock edge; after release the next grant comes from index 0.
